// File: rtl/vga_label_pkg.sv
// vga_label_pkg: character codes and cell/glyph geometry shared by the label renderer.
package vga_label_pkg;
   localparam logic [3:0] CH_DOT   = 4'd10;
   localparam logic [3:0] CH_S     = 4'd11;
   localparam logic [3:0] CH_M     = 4'd12;
   localparam logic [3:0] CH_U     = 4'd13;
   localparam logic [3:0] CH_DASH  = 4'd14;
   localparam logic [3:0] CH_BLANK = 4'd15;
   localparam int CELL_W  = 6;
   localparam int CELL_H  = 8;
   localparam int GLYPH_W = 5;
   localparam int GLYPH_H = 7;
endpackage

// File: rtl/vga_font5x7.sv
// vga_font5x7: combinational 5x7 font, row bits [4:0] with bit 4 as the leftmost column.
module vga_font5x7
   import vga_label_pkg::*;
(
   input  logic [3:0] code,
   input  logic [2:0] row,
   output logic [4:0] bits
);
   logic [34:0] g;
   always_comb begin
      case (code)
         4'd0:     g = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
         4'd1:     g = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
         4'd2:     g = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
         4'd3:     g = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
         4'd4:     g = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
         4'd5:     g = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
         4'd6:     g = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
         4'd7:     g = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
         4'd8:     g = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
         4'd9:     g = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
         CH_DOT:   g = {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
         CH_S:     g = {5'b00000, 5'b00000, 5'b01110, 5'b10000, 5'b01110, 5'b00001, 5'b11110};
         CH_M:     g = {5'b00000, 5'b00000, 5'b11010, 5'b10101, 5'b10101, 5'b10001, 5'b10001};
         CH_U:     g = {5'b00000, 5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b10011, 5'b01101};
         CH_DASH:  g = {5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000};
         default:  g = '0;
      endcase
      bits = (row == 3'(GLYPH_H)) ? 5'd0 : 5'(g >> (7'd5 * (7'd6 - 7'(row))));
   end
endmodule

// File: rtl/vga_label_render.sv
// vga_label_render: 2-stage pipelined text label overlay with frame-synchronous label commit.
// Optional LABEL_BLINK_EN adds a BLINK input and a 64-frame blink counter.
module vga_label_render
   import vga_label_pkg::*;
#(
   parameter int CHARS = 4,
   parameter int SCALE = 1,
   parameter int X0    = 243,
   parameter int Y0    = 940
) (
   input  logic               CLK_VGA,
   input  logic               RESET_N,
   input  logic [11:0]        VGA_horzCoord,
   input  logic [11:0]        VGA_vertCoord,
   input  logic               FRAME_START,
   input  logic [4*CHARS-1:0] LBL_CODES,
   input  logic               LBL_VALID,
   output logic               LBL_READY,
   output logic               PIXEL_ON
`ifdef LABEL_BLINK_EN
   ,
   input  logic               BLINK
`endif
);
   localparam int CB = CHARS > 1 ? $clog2(CHARS) : 1;
   localparam logic [12:0] XL = 13'(X0);
   localparam logic [12:0] XH = 13'(X0 + CELL_W * SCALE * CHARS);
   localparam logic [12:0] YL = 13'(Y0);
   localparam logic [12:0] YH = 13'(Y0 + CELL_H * SCALE);
   localparam logic [11:0] CWS = 12'(CELL_W * SCALE);
   localparam logic [11:0] SC  = 12'(SCALE);
   logic [11:0] dx, dy;
   logic hit;
   logic s1_hit;
   logic [CB-1:0] s1_cell;
   logic [2:0] s1_row, s1_col;
   logic [4*CHARS-1:0] lbl, pend;
   logic full;
   logic [3:0] code;
   logic [4:0] fbits, sh;
   logic mask;
   assign dx = VGA_horzCoord - XL[11:0];
   assign dy = VGA_vertCoord - YL[11:0];
   // Range tests are done in 13 bits so coordinates left of / above the label never wrap in.
   assign hit = ({1'b0, VGA_horzCoord} >= XL) && ({1'b0, VGA_horzCoord} < XH) &&
                ({1'b0, VGA_vertCoord} >= YL) && ({1'b0, VGA_vertCoord} < YH);
   assign code = 4'(lbl >> {s1_cell, 2'b00});
   assign sh = fbits << s1_col;
   assign LBL_READY = ~full;
   vga_font5x7 u_font (.code(code), .row(s1_row), .bits(fbits));
`ifdef LABEL_BLINK_EN
   logic [5:0] bcnt;
   assign mask = BLINK & bcnt[5];
   always_ff @(posedge CLK_VGA or negedge RESET_N)
      if (!RESET_N) bcnt <= '0;
      else if (FRAME_START) bcnt <= bcnt + 6'd1;
`else
   assign mask = 1'b0;
`endif
   always_ff @(posedge CLK_VGA or negedge RESET_N) begin
      if (!RESET_N) begin
         s1_hit   <= 1'b0;
         s1_cell  <= '0;
         s1_row   <= '0;
         s1_col   <= '0;
         PIXEL_ON <= 1'b0;
         lbl      <= '1;
         pend     <= '0;
         full     <= 1'b0;
      end else begin
         s1_hit   <= hit;
         s1_cell  <= CB'(dx / CWS);
         s1_col   <= 3'((dx % CWS) / SC);
         s1_row   <= 3'(dy / SC);
         PIXEL_ON <= s1_hit & sh[4] & ~mask;
         // Commit takes priority; READY is low while full, so no transfer can collide with it.
         if (FRAME_START && full) begin
            lbl  <= pend;
            full <= 1'b0;
         end else if (LBL_VALID && !full) begin
            pend <= LBL_CODES;
            full <= 1'b1;
         end
      end
   end
endmodule

// File: doc/vga_label_render.md
VGA_LABEL_RENDER -- requirements
Module: vga_label_render

Interface
REQ-001 Parameters SHALL be: CHARS, default 4, number of character cells; SCALE, default 1, pixel magnification (legal values 1, 2 or 4); X0, default 243, left edge of the label; Y0, default 940, top edge of the label.
REQ-002 Ports SHALL be:
- CLK_VGA  in  1  pixel clock.
- RESET_N  in  1  asynchronous, active-low reset.
- VGA_horzCoord  in  12  current pixel x.
- VGA_vertCoord  in  12  current pixel y.
- FRAME_START  in  1  one-cycle pulse at start of vertical blanking.
- LBL_CODES  in  4*CHARS  character codes; cell 0 in bits [3:0] and drawn leftmost.
- LBL_VALID  in  1  new label offered.
- LBL_READY  out  1  pending slot free.
- PIXEL_ON  out  1  label pixel lit.
- BLINK  in  1  blink request; port exists only under LABEL_BLINK_EN.
REQ-003 The block SHALL use one clock, CLK_VGA; RESET_N SHALL be asynchronous and active-low.

Function
REQ-004 Character codes SHALL map as follows: 0-9 digits; 10 '.'; 11 's'; 12 'm'; 13 'u'; 14 '-'; 15 blank.
REQ-005 Cell geometry SHALL be 6x8 pixels times SCALE: a 5x7 glyph with its right column (col 5) and bottom row (row 7) always dark.
REQ-006 The label region SHALL be X0 <= x < X0+6*SCALE*CHARS and Y0 <= y < Y0+8*SCALE; PIXEL_ON SHALL be 0 outside the region.
REQ-007 Inside the region, the block SHALL compute dx=x-X0 and dy=y-Y0, then cell=dx/(6*SCALE), col=(dx mod 6*SCALE)/SCALE and row=dy/SCALE.
REQ-008 PIXEL_ON SHALL equal font bit (code[cell], row, col), with bit 4 of a font row being col 0.
REQ-009 Latency SHALL be exactly 2 cycles: PIXEL_ON at cycle n+2 reflects the coordinates sampled at cycle n.
- Stage 1 registers region hit, cell, row and col.
- Stage 2 registers the font lookup.
REQ-010 Label handshake:
- A transfer occurs when LBL_VALID && LBL_READY; LBL_CODES is then captured into a pending register and LBL_READY drops on the next cycle.
- LBL_CODES SHALL be held stable by the source only in the transfer cycle.
REQ-011 Commit:
- On FRAME_START with pending full (as of the start of that cycle), pending SHALL copy into the committed label and LBL_READY SHALL rise on the next cycle.
- Rendering SHALL use only the committed label, so no label changes mid-frame.
REQ-012 Simultaneous transfer and FRAME_START with pending empty: the new label SHALL enter pending and commit at the following FRAME_START.
REQ-013 FRAME_START with pending empty SHALL leave the committed label unchanged.
REQ-014 Coordinate arithmetic SHALL be unsigned 12-bit; a coordinate below X0 or Y0 SHALL NOT wrap into the region.

Reset
REQ-015 RESET_N low SHALL immediately set:
- committed label all code 15;
- pending empty;
- LBL_READY=1;
- pipeline registers 0;
- PIXEL_ON=0;
- blink counter 0.
REQ-016 Reset mid-frame or mid-handshake SHALL discard the pending label; after release, rendering SHALL resume from the next sampled coordinate with a 2-cycle latency.

Configuration
REQ-017 With LABEL_BLINK_EN defined, the block SHALL have the BLINK port and:
- a 6-bit counter incremented on each FRAME_START;
- when BLINK=1, PIXEL_ON forced to 0 whenever counter bit 5 = 1 (32 frames on, 32 frames off);
- when BLINK=0, no masking.
REQ-018 Without LABEL_BLINK_EN, the block SHALL have no BLINK port, no counter and no masking.

Structure
REQ-019 Package vga_label_pkg SHALL hold:
- the code constants (CH_DOT, CH_S, CH_M, CH_U, CH_DASH, CH_BLANK);
- CELL_W=6, CELL_H=8, GLYPH_W=5, GLYPH_H=7.
REQ-020 Sub-module vga_font5x7 SHALL be a combinational lookup from (code[3:0], row[2:0]) to row bits [4:0]:
- '0' row0=01110;
- '1' row0=00100;
- '.' row6=00100;
- blank all 0;
- row 7 all 0 for every code.

Verification
REQ-021 Reset, then scan the full region -> PIXEL_ON=0 everywhere and LBL_READY=1.
REQ-022 Send label {1,0,10,11} and pulse FRAME_START -> LBL_READY=0 from the transfer until the cycle after FRAME_START; coordinate (245,940) presented at cycle n -> PIXEL_ON=1 at cycle n+2 (cell 0 '1', col 2).
REQ-023 With SCALE=2 and label '0' in cell 0 -> (X0+2,Y0) and (X0+3,Y0) lit; (X0,Y0) dark; (X0+10,Y0) dark (col 5).
REQ-024 Offer a new label on the same cycle as FRAME_START with pending empty -> old label persists for that frame, and the new label is shown after the next FRAME_START.
REQ-025 Assert RESET_N low mid-scan with a label pending -> PIXEL_ON=0 at once, LBL_READY=1, and the pending label never displays.
REQ-026 With LABEL_BLINK_EN and BLINK=1 -> label visible for FRAME_START pulses 0-31 and dark for pulses 32-63.
